toggle_cover_reporter: RTL

Parametrised successor to the per-bit toggle coverage strobe block. It accumulates WIDTH coverage-point hit strobes into a sticky covered bitmap and queues only first-time hits. It serialises those hits as global cover indices over a valid/ready stream, so the block is usable on FPGA and formal flows without DPI. One instance sits per coverage group. Its report stream feeds the shared coverage collector.

---
 rtl/toggle_cover_reporter.sv | 117 +++++++++++
 1 files changed

// File: rtl/toggle_cover_reporter.sv
// Toggle coverage reporter. Sticky per-point covered bitmap and a pending set
// of first-time hits. Pending hits are reported lowest bit first as global
// cover indices over a valid/ready stream.
//
// Handshake: a report transfers on a rising edge where rpt_valid && rpt_ready.
// Once rpt_valid is raised, it stays high and rpt_index stays stable until that
// transfer happens, even across clear. After a transfer, the next pending point
// is loaded on the same edge, so back-to-back reports have no gap.
module toggle_cover_reporter #(
  parameter int              WIDTH       = 32,
  parameter longint unsigned COVER_INDEX = 0,
  parameter int              IDX_W       = 64,
  localparam int             CNT_W       = $clog2(WIDTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] valid,
  input  logic             enable,
  input  logic             clear,
  output logic             rpt_valid,
  input  logic             rpt_ready,
  output logic [IDX_W-1:0] rpt_index,
  output logic [WIDTH-1:0] covered,
  output logic [CNT_W-1:0] covered_count,
  output logic             all_covered,
  output logic             fsm_state
);

  localparam int SEL_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] pending;
  logic [WIDTH-1:0] pending_next;
  logic [WIDTH-1:0] covered_next;
  logic [WIDTH-1:0] hit;
  logic [WIDTH-1:0] sel_onehot;
  logic [SEL_W-1:0] sel_idx;
  logic [CNT_W-1:0] hit_count;
  logic [CNT_W-1:0] count_next;
  logic             sample;
  logic             handshake;
  logic             load;

  // A held report is visible only in SEND, so rpt_valid follows the state register.
  assign rpt_valid = (state == SEND);
  assign fsm_state = (state == SEND);

  // Lowest set pending bit as an index and as a one-hot mask.
  // The loop runs downward, so the last match is the lowest bit.
  always_comb begin
    sel_idx    = '0;
    sel_onehot = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (pending[i]) begin
        sel_idx       = SEL_W'(i);
        sel_onehot    = '0;
        sel_onehot[i] = 1'b1;
      end
    end
  end

  // Sample new hits and count them. Clear masks sampling for the cycle.
  always_comb begin
    sample    = enable & ~clear;
    hit       = sample ? (valid & ~covered) : '0;
    hit_count = '0;
    for (int i = 0; i < WIDTH; i++) begin
      hit_count = hit_count + CNT_W'(hit[i]);
    end
    covered_next = clear ? '0 : (covered | (sample ? valid : '0));
    count_next   = clear ? '0 : (covered_count + hit_count);
  end

  // Decide whether a new report loads this edge, and compute the next pending set.
  // Clear empties pending and blocks any new load. A held report still completes.
  always_comb begin
    handshake    = rpt_valid & rpt_ready;
    load         = ~clear && (pending != '0) && ((state == IDLE) || handshake);
    pending_next = clear ? '0 : ((pending & ~(load ? sel_onehot : '0)) | hit);
    state_next   = state;
    case (state)
      IDLE:    if (load) state_next = SEND;
      SEND:    if (handshake && !load) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Coverage bitmap, pending set, count, and report index registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      covered       <= '0;
      pending       <= '0;
      covered_count <= '0;
      all_covered   <= 1'b0;
      rpt_index     <= '0;
    end else begin
      covered       <= covered_next;
      pending       <= pending_next;
      covered_count <= count_next;
      all_covered   <= (count_next == CNT_W'(WIDTH));
      if (load) rpt_index <= IDX_W'(COVER_INDEX) + IDX_W'(sel_idx);
    end
  end

endmodule
